// File: rtl/edge_pkg.sv
// edge_pkg
// Shared definitions for the streaming 3x3 Sobel edge detector: default
// frame geometry and pixel width, the detection-mode encodings, and the
// magnitude saturation helper.
package edge_pkg;

   localparam int DEF_IMG_W = 64;
   localparam int DEF_IMG_H = 64;
   localparam int DEF_PIX_W = 8;

   typedef enum logic [1:0] {
      MODE_SUM    = 2'b00,   // |Gx| + |Gy|
      MODE_GX     = 2'b01,   // |Gx| only
      MODE_GY     = 2'b10,   // |Gy| only
      MODE_BYPASS = 2'b11    // centre pixel
   } mode_t;

   // Clamp an unsigned magnitude to the largest value a pix_w-bit pixel
   // can hold.
   function automatic logic [31:0] sat_mag(input logic [31:0] mag,
                                           input int unsigned pix_w);
      logic [31:0] lim;
      lim = (32'd1 << pix_w) - 32'd1;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// edge_line_buffer
// Single-port-pair synchronous RAM holding two delayed image rows side by
// side in each word. One read and one write per cycle; the read data is
// registered (available the cycle after the address is presented).
// Storage is intentionally not reset.
//
// Ports:
//   clk      rising-edge clock
//   rd_addr  read column address
//   rd_data  registered read word {row-1 pixel, row-2 pixel}
//   wr_en    write strobe
//   wr_addr  write column address
//   wr_data  write word {row-1 pixel, row-2 pixel}
module edge_line_buffer
   import edge_pkg::*;
#(
   parameter int DEPTH = DEF_IMG_W,
   parameter int WIDTH = 2 * DEF_PIX_W,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/edge_detect_stream.sv
// edge_detect_stream
// Streaming 3x3 Sobel edge detector over raster-order pixels. Produces one
// registered result per interior pixel, one cycle after the pixel that
// completes its 3x3 neighbourhood is accepted.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   enb        block enable; input ignored and counters hold when low
//   clear      synchronous frame abort (overrides in_valid)
//   mode       00 |Gx|+|Gy|, 01 |Gx|, 10 |Gy|, 11 bypass centre pixel
//   threshold  binarisation level, 0 = raw saturated magnitude
//   in_valid   in_pixel valid this cycle
//   in_pixel   input pixel
//   out_valid  out_edge valid this cycle
//   out_edge   edge result (holds when out_valid is low)
//   complete   pulse with the last output of a frame
module edge_detect_stream
   import edge_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int PIX_W = DEF_PIX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enb,
   input  logic             clear,
   input  logic [1:0]       mode,
   input  logic [PIX_W-1:0] threshold,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_edge,
   output logic             complete
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int MW = PIX_W + 3;

   logic             accept;
   logic [CW-1:0]    col;
   logic [CW-1:0]    col_next;
   logic [CW-1:0]    rd_addr;
   logic [RW-1:0]    row;
   logic             col_last;
   logic             row_last;

   logic [2*PIX_W-1:0] lb_rd;
   logic [PIX_W-1:0]   top;
   logic [PIX_W-1:0]   mid;

   // Window columns c-2 (t1/m1/b1) and c-1 (t2/m2/b2) for rows r-2, r-1, r.
   // Column c comes straight from the line buffer and in_pixel.
   logic [PIX_W-1:0] t1, t2, m1, m2, b1, b2;

   logic [PIX_W+1:0] gx_a, gx_b, gy_a, gy_b;
   logic [PIX_W+1:0] abs_gx, abs_gy;
   logic [MW-1:0]    mag;
   logic [PIX_W-1:0] sat;
   logic [PIX_W-1:0] result;
   logic             emit;
   logic             emit_last;

   assign accept   = enb & in_valid & ~clear;
   assign col_last = (col == CW'(IMG_W - 1));
   assign row_last = (row == RW'(IMG_H - 1));
   assign col_next = col_last ? '0 : col + 1'b1;

   // The RAM read is registered, so the word for the next column to be
   // accepted is prefetched: on acceptance address the following column,
   // otherwise keep re-reading the current one. Read and write never hit
   // the same address because the write always targets col.
   always_comb begin
      rd_addr = col;
      if (clear) begin
         rd_addr = '0;
      end else if (accept) begin
         rd_addr = col_next;
      end
   end

   assign top = lb_rd[PIX_W-1:0];
   assign mid = lb_rd[2*PIX_W-1:PIX_W];

   edge_line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (2 * PIX_W)
   ) u_line_buffer (
      .clk     (clk),
      .rd_addr (rd_addr),
      .rd_data (lb_rd),
      .wr_en   (accept),
      .wr_addr (col),
      .wr_data ({in_pixel, mid})
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         col <= col_next;
         if (col_last) begin
            row <= row_last ? '0 : row + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t1 <= '0;
         t2 <= '0;
         m1 <= '0;
         m2 <= '0;
         b1 <= '0;
         b2 <= '0;
      end else if (accept) begin
         t1 <= t2;
         t2 <= top;
         m1 <= m2;
         m2 <= mid;
         b1 <= b2;
         b2 <= in_pixel;
      end
   end

   // Gradients are evaluated on the window as it will be after this shift,
   // so the result can be registered on the acceptance edge itself.
   always_comb begin
      gx_a = {2'b00, top} + {1'b0, mid, 1'b0} + {2'b00, in_pixel};
      gx_b = {2'b00, t1}  + {1'b0, m1, 1'b0}  + {2'b00, b1};
      gy_a = {2'b00, b1}  + {1'b0, b2, 1'b0}  + {2'b00, in_pixel};
      gy_b = {2'b00, t1}  + {1'b0, t2, 1'b0}  + {2'b00, top};
      abs_gx = (gx_a >= gx_b) ? (gx_a - gx_b) : (gx_b - gx_a);
      abs_gy = (gy_a >= gy_b) ? (gy_a - gy_b) : (gy_b - gy_a);

      case (mode_t'(mode))
         MODE_SUM:    mag = {1'b0, abs_gx} + {1'b0, abs_gy};
         MODE_GX:     mag = {1'b0, abs_gx};
         MODE_GY:     mag = {1'b0, abs_gy};
         MODE_BYPASS: mag = {3'b000, m2};
         default:     mag = '0;
      endcase

      sat = PIX_W'(sat_mag(32'(mag), unsigned'(PIX_W)));

      if (threshold == '0) begin
         result = sat;
      end else begin
         result = (sat >= threshold) ? '1 : '0;
      end

      emit      = accept && (row >= RW'(2)) && (col >= CW'(2));
      emit_last = emit && row_last && col_last;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_edge  <= '0;
         complete  <= 1'b0;
      end else if (clear) begin
         out_valid <= 1'b0;
         complete  <= 1'b0;
      end else begin
         out_valid <= emit;
         complete  <= emit_last;
         if (emit) begin
            out_edge <= result;
         end
      end
   end

endmodule

// File: doc/edge_detect_stream.md
EDGE_DETECT_STREAM -- requirements
Module: edge_detect_stream

Interface
REQ-001 Parameter IMG_W, default 64, pixels per row (≥3).
REQ-002 Parameter IMG_H, default 64, rows per frame (≥3).
REQ-003 Parameter PIX_W, default 8, pixel bit width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enb  input  1  block enable; when low, input is ignored and all counters hold.
REQ-007 clear  input  1  synchronous frame abort.
REQ-008 mode  input  2  detection mode: 00 |Gx|+|Gy|, 01 |Gx| only, 10 |Gy| only, 11 bypass (centre pixel).
REQ-009 threshold  input  PIX_W  binarisation level; 0 selects raw saturated magnitude.
REQ-010 in_valid  input  1  in_pixel is valid this cycle.
REQ-011 in_pixel  input  PIX_W  raster-order pixel, row-major, left to right.
REQ-012 out_valid  output  1  out_edge is valid this cycle.
REQ-013 out_edge  output  PIX_W  edge result for one interior pixel.
REQ-014 complete  output  1  one-cycle pulse with the last output of a frame.

Function
REQ-015 A pixel SHALL be accepted on a rising edge where enb=1, in_valid=1 and clear=0; there is no backpressure.
REQ-016 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance only on acceptance; col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1) both wrap to 0 and the next frame begins without a gap.
REQ-017 Two line buffers of depth IMG_W SHALL hold rows row-1 and row-2; a 3x3 window register SHALL shift one column per acceptance.
REQ-018 Only interior centres (1..IMG_H-2, 1..IMG_W-2) SHALL produce output: exactly (IMG_H-2)*(IMG_W-2) outputs per frame, none for border pixels.
REQ-019 Acceptance of pixel (r,c) with r≥2 and c≥2 SHALL produce the output for centre (r-1,c-1), registered on the next rising edge (out_valid high for exactly one cycle).
REQ-020 Gx = (p02+2p12+p22)-(p00+2p10+p20); Gy = (p20+2p21+p22)-(p00+2p01+p02); magnitude is computed at PIX_W+3 bits unsigned without overflow.
REQ-021 The magnitude SHALL saturate to 2^PIX_W-1; in bypass mode the result is p11.
REQ-022 If threshold≠0, out_edge SHALL be all-ones when the saturated result ≥ threshold and 0 otherwise; threshold also applies in bypass mode.
REQ-023 mode and threshold SHALL be sampled on the output-register edge; changing them mid-frame takes effect on the next output.
REQ-024 complete SHALL assert in the same cycle as out_valid for centre (IMG_H-2, IMG_W-2).
REQ-025 When out_valid=0, out_edge SHALL hold its previous value.
REQ-026 clear=1 SHALL zero col, row, out_valid and complete on the next edge and discard any pending output; clear overrides a simultaneous in_valid.
REQ-027 Input gaps (in_valid=0 or enb=0) SHALL NOT change any output value or count versus continuous streaming.

Reset
REQ-028 While reset=0: col=0, row=0, window registers=0, out_valid=0, out_edge=0, complete=0.
REQ-029 Line-buffer storage SHALL NOT be reset; a row is never read before it has been written in the current frame.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; the first frame after release starts at pixel (0,0).

Structure
REQ-031 Shared package edge_pkg SHALL hold the mode encodings, default IMG_W/IMG_H/PIX_W and the saturation function.
REQ-032 Sub-module edge_line_buffer (depth IMG_W, width 2*PIX_W, one read and one write per cycle, synchronous RAM) SHALL implement both delayed rows in a single instance.

Verification
REQ-033 8x8 frame all 100, mode 00, threshold 0 -> 36 outputs, all 0; complete pulses once, with the 36th output.
REQ-034 8x8 with cols 0-3=0 and cols 4-7=255, mode 01, threshold 0 -> 255 at centre cols 3 and 4, 0 elsewhere; mode 10 -> all 0.
REQ-035 Uniform horizontal gradient giving |Gx|=40: threshold 50 -> all 0; threshold 30 -> all 255.
REQ-036 Same frame with random in_valid/enb gaps -> output stream identical to continuous run; 36 outputs, one complete.
REQ-037 reset pulled low at row 4 (or clear at row 4), then a full frame -> no stale outputs; 36 correct outputs; complete only at the end of the new frame.
REQ-038 Two back-to-back frames with no gap -> 72 outputs, complete pulsed twice, second frame free of contamination from the first.
